axis_add_sub_pipe: RTL and testbench
====================================

Name: axis_add_sub_pipe

Overview:
- Pipelined, parametrised adder/subtractor with AXI-Stream valid/ready handshakes on input and output.
- Carry chain is split into STAGES segments, one register stage each, so wide operands close timing at full rate.
- Adds per-transfer add/subtract select, carry/borrow in, overflow flag and optional saturation.
- Used as the datapath arithmetic primitive behind AXI-Stream DSP and accumulator blocks.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be ≥1.
- STAGES, 2: carry-pipeline segments, which is also the latency in cycles. Range 1..8. WIDTH % STAGES must be 0; otherwise elaboration prints an error and calls $finish.
- SIGNED, 1: 1 treats A and B as two's complement; 0 treats them as unsigned.
- SATURATE, 0: 1 clamps the result on overflow; 0 wraps.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- S_A  in  WIDTH  operand A.
- S_B  in  WIDTH  operand B.
- S_ADD  in  1  1 = A+B+C_IN; 0 = A−B−S_C_IN (S_C_IN acts as borrow in).
- S_C_IN  in  1  carry in (add) or borrow in (subtract), active high.
- S_VALID  in  1  input transfer valid.
- S_READY  out  1  input transfer accepted when S_VALID&&S_READY.
- M_S  out  WIDTH  result.
- M_C_OUT  out  1  add: carry out of MSB; subtract: borrow out (1 = A < B+borrow, unsigned sense).
- M_OVF  out  1  overflow/underflow for the selected SIGNED mode.
- M_VALID  out  1  output valid.
- M_READY  in  1  downstream ready.

Behaviour:
- Reset: all stage valid bits 0, M_VALID=0, M_S=0, M_C_OUT=0, M_OVF=0, S_READY=1 when RST=0 follows. Reset asserted mid-operation discards every in-flight item; nothing is emitted afterwards from those items.
- Arithmetic: subtract is A + ~B + ~S_C_IN. The internal carry is inverted back to borrow for M_C_OUT.
- Segment SEG=WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] using the registered carry from stage k−1.
- Lower result bits are carried forward as registered data. Upper operand bits are delayed, along with the op bit, so that each segment's operands meet their carry.
- Overflow when SIGNED=1: carry into MSB XOR carry out of MSB.
- Overflow when SIGNED=0: add → carry out = 1; subtract → borrow out = 1.
- Saturation (SATURATE=1, M_OVF=1):
  - signed add/sub positive overflow → 0111..1; negative → 1000..0.
  - unsigned add → all ones; unsigned subtract → 0.
  - M_OVF and M_C_OUT still report raw status.
- Latency: an item accepted at edge N appears with M_VALID=1 after edge N+STAGES, if not stalled.
- Throughput: one item per cycle.
- Flow control is per stage. Stage i loads when it is empty or stage i+1 (output register for the last stage) is loading or draining. Bubbles collapse; a stall does not freeze upstream empty stages.
- S_READY = stage 0 empty OR stage 0 advancing. This may depend combinationally on M_READY; no other input-to-output combinational paths exist.
- M_S/M_C_OUT/M_OVF hold stable while M_VALID=1 and M_READY=0. M_VALID never drops without a handshake.
- Pipeline full with M_READY=0: S_READY=0 and the input is held. Simultaneous drain and accept in the same cycle is allowed with no bubble.
- No data is reordered, duplicated or dropped except at reset.

Test Plan:
- WIDTH=8, STAGES=2, SIGNED=0, SATURATE=0, M_READY=1; send A=0xF0, B=0x20, ADD=1, C_IN=1 → after 2 cycles M_S=0x11, M_C_OUT=1, M_OVF=1.
- Same config; A=0x10, B=0x20, ADD=0, C_IN=0 → M_S=0xF0, M_C_OUT=1, M_OVF=1. Then A=0x30, B=0x20, C_IN=1 → M_S=0x0F, M_C_OUT=0, M_OVF=0.
- SIGNED=1, SATURATE=1: A=0x7F, B=0x01 add → M_S=0x7F, M_OVF=1. A=0x80, B=0x01 subtract → M_S=0x80, M_OVF=1. A=0x05, B=0xFD add → M_S=0x02, M_OVF=0.
- Backpressure: stream 10 random items with M_READY toggling on a pseudo-random pattern. Check against a scoreboard that outputs are in order, there is no loss or duplication, outputs are stable while stalled, and S_READY=0 only when all stages plus output are full.
- Reset mid-stream: assert RST asynchronously with 2 items in flight → M_VALID=0 immediately, M_S=0. After release, the next input emerges after 2 cycles with the correct value and no stale items.
- WIDTH=32, STAGES=4, full-rate random stream of 1000 items, M_READY=1 → one result per cycle after 4-cycle latency, all matching the reference model.

Source files
------------

// File: rtl/axis_add_sub_pipe.sv
// axis_add_sub_pipe: AXI-Stream adder/subtractor. The carry chain is cut into
// STAGES registered segments, followed by a registered output slice that
// applies overflow detection and optional saturation.
module axis_add_sub_pipe #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] S_A,
    input  logic [WIDTH-1:0] S_B,
    input  logic             S_ADD,
    input  logic             S_C_IN,
    input  logic             S_VALID,
    output logic             S_READY,
    output logic [WIDTH-1:0] M_S,
    output logic             M_C_OUT,
    output logic             M_OVF,
    output logic             M_VALID,
    input  logic             M_READY
);

    localparam int SEG = WIDTH / STAGES;
    localparam logic [WIDTH-1:0] SAT_POS = {WIDTH{1'b1}} >> 1;
    localparam logic [WIDTH-1:0] SAT_NEG = ~SAT_POS;

    if (WIDTH < 1 || STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $fatal(1, "axis_add_sub_pipe: WIDTH=%0d must be >=1 and divisible by STAGES=%0d (1..8)",
               WIDTH, STAGES);
    end

    // One carry segment: returns {carry out, carry into segment MSB, sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a,
                                               input logic [SEG-1:0] b,
                                               input logic           c);
        logic [SEG:0] full;
        full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
        return {full[SEG], full[SEG-1] ^ a[SEG-1] ^ b[SEG-1], full[SEG-1:0]};
    endfunction

    // Per-stage state. b_q holds B already inverted for subtract, so every
    // segment is a plain add; add_q remembers the op for the output slice.
    logic             vld_q [STAGES];
    logic             vld_d [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             cm_q  [STAGES];
    logic             cm_d  [STAGES];
    logic             add_q [STAGES];
    logic             add_d [STAGES];
    logic             load  [STAGES];
    logic             out_load;

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_s_q, m_s_d;
    logic             m_c_out_q, m_c_out_d;
    logic             m_ovf_q, m_ovf_d;

    // Load enables: a stage loads if it, or any stage below it, is empty,
    // or the output slice is empty or draining; bubbles therefore collapse.
    always_comb begin
        logic l;
        out_load = !m_valid_q || M_READY;
        for (int i = 0; i < STAGES; i++) begin
            l = out_load;
            for (int j = i; j < STAGES; j++) begin
                l = l | !vld_q[j];
            end
            load[i] = l;
        end
    end

    assign S_READY = load[0];

    // Carry pipeline: stage k adds segment k using the carry registered by stage k-1.
    always_comb begin
        logic [SEG+1:0]   r;
        logic [WIDTH-1:0] b_eff;
        logic             c_eff;
        // NOTE: every variable gets a default before any branch, otherwise a
        // path that skips an assignment infers a latch.
        r     = '0;
        b_eff = '0;
        c_eff = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            vld_d[i] = vld_q[i];
            sum_d[i] = sum_q[i];
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            cy_d[i]  = cy_q[i];
            cm_d[i]  = cm_q[i];
            add_d[i] = add_q[i];
        end

        if (load[0]) begin
            vld_d[0] = S_VALID;
            if (S_VALID) begin
                // Subtract as A + ~B + ~borrow.
                b_eff    = S_ADD ? S_B : ~S_B;
                c_eff    = S_ADD ? S_C_IN : ~S_C_IN;
                r        = seg_add(S_A[SEG-1:0], b_eff[SEG-1:0], c_eff);
                sum_d[0] = '0;
                sum_d[0][SEG-1:0] = r[SEG-1:0];
                a_d[0]   = S_A;
                b_d[0]   = b_eff;
                cy_d[0]  = r[SEG+1];
                cm_d[0]  = r[SEG];
                add_d[0] = S_ADD;
            end
        end

        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    r        = seg_add(a_q[k-1][k*SEG +: SEG], b_q[k-1][k*SEG +: SEG], cy_q[k-1]);
                    sum_d[k] = sum_q[k-1];
                    sum_d[k][k*SEG +: SEG] = r[SEG-1:0];
                    a_d[k]   = a_q[k-1];
                    b_d[k]   = b_q[k-1];
                    cy_d[k]  = r[SEG+1];
                    cm_d[k]  = r[SEG];
                    add_d[k] = add_q[k-1];
                end
            end
        end
    end

    // Output slice: status flags, optional clamp; holds while stalled.
    always_comb begin
        logic [WIDTH-1:0] raw;
        logic             cy;
        logic             c_out;
        logic             ovf;
        m_valid_d = m_valid_q;
        m_s_d     = m_s_q;
        m_c_out_d = m_c_out_q;
        m_ovf_d   = m_ovf_q;
        raw       = sum_q[STAGES-1];
        cy        = cy_q[STAGES-1];
        c_out     = add_q[STAGES-1] ? cy : ~cy;
        ovf       = (SIGNED != 0) ? (cy ^ cm_q[STAGES-1]) : c_out;
        if (out_load) begin
            m_valid_d = vld_q[STAGES-1];
            if (vld_q[STAGES-1]) begin
                m_s_d     = raw;
                m_c_out_d = c_out;
                m_ovf_d   = ovf;
                if (SATURATE != 0 && ovf) begin
                    if (SIGNED != 0) begin
                        // A wrapped negative result means positive overflow.
                        m_s_d = raw[WIDTH-1] ? SAT_POS : SAT_NEG;
                    end else begin
                        m_s_d = add_q[STAGES-1] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
                    end
                end
            end
        end
    end

    // Control state and visible outputs: cleared by reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            for (int i = 0; i < STAGES; i++) vld_q[i] <= 1'b0;
            m_valid_q <= 1'b0;
            m_s_q     <= '0;
            m_c_out_q <= 1'b0;
            m_ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) vld_q[i] <= vld_d[i];
            m_valid_q <= m_valid_d;
            m_s_q     <= m_s_d;
            m_c_out_q <= m_c_out_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    // Pipeline datapath registers.
    // NOTE: these carry no reset; contents are only observed behind a valid
    // bit, and leaving them unreset keeps the reset net off the wide datapath.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STAGES; i++) begin
            sum_q[i] <= sum_d[i];
            a_q[i]   <= a_d[i];
            b_q[i]   <= b_d[i];
            cy_q[i]  <= cy_d[i];
            cm_q[i]  <= cm_d[i];
            add_q[i] <= add_d[i];
        end
    end

    assign M_VALID = m_valid_q;
    assign M_S     = m_s_q;
    assign M_C_OUT = m_c_out_q;
    assign M_OVF   = m_ovf_q;

endmodule

// File: tb/tb_axis_add_sub_pipe.sv
// tb_axis_add_sub_pipe: three configurations of axis_add_sub_pipe driven with
// directed and random AXI-Stream traffic, checked against an arithmetic model.
module tb_axis_add_sub_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        add;
        logic        cin;
        bit          use_exp;
        logic [31:0] es;
        logic        ec;
        logic        eo;
    } item_t;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] opa  [3];
    logic [31:0] opb  [3];
    logic        tadd [3];
    logic        tcin [3];
    logic        tvld [3];
    logic        tmr  [3];
    logic        srdy [3];
    logic        mc   [3];
    logic        mo   [3];
    logic        mv   [3];
    logic [7:0]  s0, s1;
    logic [31:0] s2;

    int    n_checks = 0;
    int    n_fail   = 0;
    item_t in_q[$];

    always #5 clk = ~clk;

    axis_add_sub_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(0), .SATURATE(0)) u_dut0 (
        .CLK(clk), .RST(rst), .S_A(opa[0][7:0]), .S_B(opb[0][7:0]), .S_ADD(tadd[0]),
        .S_C_IN(tcin[0]), .S_VALID(tvld[0]), .S_READY(srdy[0]), .M_S(s0),
        .M_C_OUT(mc[0]), .M_OVF(mo[0]), .M_VALID(mv[0]), .M_READY(tmr[0]));

    axis_add_sub_pipe #(.WIDTH(8), .STAGES(2), .SIGNED(1), .SATURATE(1)) u_dut1 (
        .CLK(clk), .RST(rst), .S_A(opa[1][7:0]), .S_B(opb[1][7:0]), .S_ADD(tadd[1]),
        .S_C_IN(tcin[1]), .S_VALID(tvld[1]), .S_READY(srdy[1]), .M_S(s1),
        .M_C_OUT(mc[1]), .M_OVF(mo[1]), .M_VALID(mv[1]), .M_READY(tmr[1]));

    axis_add_sub_pipe #(.WIDTH(32), .STAGES(4), .SIGNED(1), .SATURATE(0)) u_dut2 (
        .CLK(clk), .RST(rst), .S_A(opa[2]), .S_B(opb[2]), .S_ADD(tadd[2]),
        .S_C_IN(tcin[2]), .S_VALID(tvld[2]), .S_READY(srdy[2]), .M_S(s2),
        .M_C_OUT(mc[2]), .M_OVF(mo[2]), .M_VALID(mv[2]), .M_READY(tmr[2]));

    function automatic int wid(int d);
        return (d == 2) ? 32 : 8;
    endfunction

    function automatic int stg(int d);
        return (d == 2) ? 4 : 2;
    endfunction

    function automatic bit sgn(int d);
        return d != 0;
    endfunction

    function automatic bit sat(int d);
        return d == 1;
    endfunction

    function automatic logic [31:0] get_s(int d);
        case (d)
            0:       return {24'h0, s0};
            1:       return {24'h0, s1};
            default: return s2;
        endcase
    endfunction

    // Reference: exact integer arithmetic, then the range rules for overflow.
    function automatic exp_t model(int d, item_t it);
        exp_t   e;
        longint m, h, ua, ub, t, sa, sb, tr, ci;
        m  = longint'(1) << wid(d);
        h  = m / 2;
        ci = it.cin ? 1 : 0;
        ua = longint'(it.a) & (m - 1);
        ub = longint'(it.b) & (m - 1);
        t  = it.add ? ua + ub + ci : ua - ub - ci;
        e.c = it.add ? (t >= m) : (t < 0);
        sa = (ua >= h) ? ua - m : ua;
        sb = (ub >= h) ? ub - m : ub;
        tr = it.add ? sa + sb + ci : sa - sb - ci;
        e.o = sgn(d) ? ((tr >= h) || (tr < -h)) : e.c;
        t = t & (m - 1);
        if (sat(d) && e.o) begin
            if (sgn(d)) t = (tr > 0) ? h - 1 : h;
            else        t = it.add ? m - 1 : 0;
        end
        e.s = 32'(t);
        e.t = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic item_t mk(logic [31:0] a, logic [31:0] b, logic add, logic cin,
                                 bit use_exp, logic [31:0] es, logic ec, logic eo);
        item_t it;
        it.a = a; it.b = b; it.add = add; it.cin = cin;
        it.use_exp = use_exp; it.es = es; it.ec = ec; it.eo = eo;
        return it;
    endfunction

    // Sends in_q plus n_rand random items to DUT d and scoreboards the output.
    task automatic run(input int d, input int n_rand, input int rdy_pct,
                       input int vld_pct, input bit chk_lat);
        exp_t        exp_q[$];
        exp_t        e;
        item_t       cur;
        bit          have    = 0;
        bit          stalled = 0;
        int          cyc     = 0;
        int          budget;
        logic [31:0] hs;
        logic        hc, ho;
        for (int i = 0; i < n_rand; i++) begin
            in_q.push_back(mk($urandom, $urandom, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 0, '0, 1'b0, 1'b0));
        end
        budget = 200 + 20 * in_q.size();
        hs = '0; hc = 1'b0; ho = 1'b0;
        while ((in_q.size() > 0 || have || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            if (!have && in_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
                cur  = in_q.pop_front();
                have = 1;
            end
            tvld[d] = have;
            opa[d]  = cur.a;
            opb[d]  = cur.b;
            tadd[d] = cur.add;
            tcin[d] = cur.cin;
            tmr[d]  = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (stalled) begin
                check("hold_valid", mv[d], 1'b1);
                check("hold_s", get_s(d), hs);
                check("hold_c_out", mc[d], hc);
                check("hold_ovf", mo[d], ho);
            end
            // Input is refused only when every stage and the output hold data
            // and the output is not draining.
            check("s_ready", srdy[d], (exp_q.size() < stg(d) + 1) || tmr[d]);
            if (mv[d] && tmr[d]) begin
                if (exp_q.size() == 0) begin
                    check("stale_out", mv[d], 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("m_s", get_s(d), e.s);
                    check("m_c_out", mc[d], e.c);
                    check("m_ovf", mo[d], e.o);
                    // Accepted at the edge closing iteration e.t, visible after
                    // STAGES further edges.
                    if (chk_lat) check("latency", 64'(cyc - e.t), 64'(stg(d) + 1));
                end
            end
            stalled = mv[d] && !tmr[d];
            hs = get_s(d); hc = mc[d]; ho = mo[d];
            if (have && srdy[d]) begin
                if (cur.use_exp) begin
                    e.s = cur.es; e.c = cur.ec; e.o = cur.eo;
                end else begin
                    e = model(d, cur);
                end
                e.t = cyc;
                exp_q.push_back(e);
                have = 0;
            end
            cyc++;
        end
        check("drained", 64'(in_q.size() + int'(have) + exp_q.size()), 64'(0));
        in_q.delete();
        for (int i = 0; i < stg(d) + 3; i++) begin
            @(negedge clk);
            tvld[d] = 1'b0;
            tmr[d]  = 1'b1;
            #1;
            check("idle_valid", mv[d], 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            opa[d] = '0; opb[d] = '0; tadd[d] = 1'b0; tcin[d] = 1'b0;
            tvld[d] = 1'b0; tmr[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_valid%0d", d), mv[d], 1'b0);
            check($sformatf("rst_s%0d", d), get_s(d), 32'h0);
            check($sformatf("rst_c_out%0d", d), mc[d], 1'b0);
            check($sformatf("rst_ovf%0d", d), mo[d], 1'b0);
            check($sformatf("rst_ready%0d", d), srdy[d], 1'b1);
        end

        // Unsigned wrap: carry and borrow as overflow.
        in_q.push_back(mk(32'hF0, 32'h20, 1'b1, 1'b1, 1, 32'h11, 1'b1, 1'b1));
        in_q.push_back(mk(32'h10, 32'h20, 1'b0, 1'b0, 1, 32'hF0, 1'b1, 1'b1));
        in_q.push_back(mk(32'h30, 32'h20, 1'b0, 1'b1, 1, 32'h0F, 1'b0, 1'b0));
        run(0, 0, 100, 100, 1);

        // Signed saturation at both rails, and a non-overflowing add.
        in_q.push_back(mk(32'h7F, 32'h01, 1'b1, 1'b0, 1, 32'h7F, 1'b0, 1'b1));
        in_q.push_back(mk(32'h80, 32'h01, 1'b0, 1'b0, 1, 32'h80, 1'b0, 1'b1));
        in_q.push_back(mk(32'h05, 32'hFD, 1'b1, 1'b0, 1, 32'h02, 1'b1, 1'b0));
        run(1, 0, 100, 100, 1);

        // Backpressure with random gaps on both sides.
        run(0, 40, 35, 80, 0);
        run(1, 40, 35, 80, 0);

        // Reset with items in flight: everything in the pipe is discarded.
        @(negedge clk);
        tmr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tvld[0] = 1'b1; opa[0] = 32'(i + 1); opb[0] = 32'h1; tadd[0] = 1'b1; tcin[0] = 1'b0;
            @(negedge clk);
        end
        tvld[0] = 1'b0;
        #1;
        check("pre_rst_valid", mv[0], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", mv[0], 1'b0);
        check("mid_rst_s", get_s(0), 32'h0);
        check("mid_rst_c_out", mc[0], 1'b0);
        check("mid_rst_ovf", mo[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_q.push_back(mk(32'h42, 32'h13, 1'b1, 1'b0, 1, 32'h55, 1'b0, 1'b0));
        run(0, 0, 100, 100, 1);

        // Wide config: segment-crossing carries, then a full-rate random stream.
        in_q.push_back(mk(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 0, '0, 1'b0, 1'b0));
        in_q.push_back(mk(32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 0, '0, 1'b0, 1'b0));
        in_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b1, 0, '0, 1'b0, 1'b0));
        in_q.push_back(mk(32'h8000_0000, 32'h1, 1'b0, 1'b0, 0, '0, 1'b0, 1'b0));
        run(2, 1000, 100, 100, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
